// File: rtl/iter_ctrl_div_sqrt_mvp.sv
// iter_ctrl_div_sqrt_mvp: sequencer for the radix-2 iterative mantissa
// divide / square-root datapath. One operation is accepted through a
// start/ready handshake. The result is a truncated quotient or root plus a
// sticky bit that is set when the final remainder is non-zero.
//
// Handshake: Start_SI is sampled only on a rising edge where Ready_SO=1
// (state IDLE or DONE). Done_SO is a one-cycle pulse in DONE. Result_DO and
// Sticky_SO are valid in that cycle and hold until the next DONE or reset.
//
// Optional build macro: DIV_SQRT_KILL_EN adds the Kill_SI abort input.
//
// Datapath notes:
//   The partial remainder is kept signed. Each step subtracts when the
//   previous remainder is >= 0 and adds otherwise (non-restoring). The
//   adder is modelled as sum = P + (sub ? ~Y : Y) + cin. cin is set for
//   subtraction so that the two's-complement negation is exact.
//   Divide: Y = divisor. The first step uses P = dividend.
//           Later steps use P = 2*rem.
//   Sqrt  : P = 4*rem + next radicand bit pair.
//           Y = 4Q+1 when subtracting, 4Q+3 when adding.
//   On the last step a negative remainder is corrected by adding back the
//   subtrahend of that step. This makes the sticky bit exact.
module iter_ctrl_div_sqrt_mvp #(
  parameter int WIDTH = 25
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Start_SI,
  input  logic             Div_SI,
`ifdef DIV_SQRT_KILL_EN
  input  logic             Kill_SI,
`endif
  input  logic [WIDTH-1:0] Operand_a_DI,
  input  logic [WIDTH-1:0] Operand_b_DI,
  output logic             Ready_SO,
  output logic             Busy_SO,
  output logic             Done_SO,
  output logic [WIDTH:0]   Result_DO,
  output logic             Sticky_SO,
  output logic [1:0]       Dbg_State_SO
);

  // Remainder width. It leaves headroom for 4*rem during the sqrt steps.
  localparam int RW = WIDTH + 5;
  localparam int CW = $clog2(WIDTH + 2);
  // Final counter values: N-1 for divide (N = WIDTH+1) and sqrt (N = WIDTH).
  localparam logic [CW-1:0] LAST_DIV  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_SQRT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // dividend, or radicand shift register
  logic [WIDTH-1:0] opb_q, opb_d;   // divisor
  logic [RW-1:0]    rem_q, rem_d;   // signed partial remainder
  logic [WIDTH:0]   quo_q, quo_d;   // quotient / root digits so far
  logic [WIDTH:0]   res_q, res_d;
  logic             sticky_q, sticky_d;

  logic             kill_s;
  logic             sub_s;
  logic             adder_cin_s;
  logic [RW-1:0]    p_s;
  logic [RW-1:0]    y_s;
  logic [RW-1:0]    y_corr_s;
  logic [RW-1:0]    sum_s;
  logic [RW-1:0]    rem_fix_s;
  logic             digit_s;
  logic             last_s;
  logic [WIDTH:0]   quo_next_s;

`ifdef DIV_SQRT_KILL_EN
  assign kill_s = Kill_SI;
`else
  assign kill_s = 1'b0;
`endif

  // Add/subtract step: pick the operands, run the adder, derive the digit
  // and the corrected final remainder.
  always_comb begin
    sub_s       = ~rem_q[RW-1];
    adder_cin_s = sub_s;
    p_s         = '0;
    y_s         = '0;
    y_corr_s    = '0;
    if (div_q) begin
      if (cnt_q == '0) begin
        p_s = {{(RW-WIDTH){1'b0}}, opa_q};
      end else begin
        p_s = {rem_q[RW-2:0], 1'b0};
      end
      y_s      = {{(RW-WIDTH){1'b0}}, opb_q};
      y_corr_s = y_s;
    end else begin
      p_s = {rem_q[RW-3:0], 2'b00} + {{(RW-2){1'b0}}, opa_q[WIDTH-1:WIDTH-2]};
      if (sub_s) begin
        y_s = {{(RW-WIDTH-3){1'b0}}, quo_q, 2'b01};
      end else begin
        y_s = {{(RW-WIDTH-3){1'b0}}, quo_q, 2'b11};
      end
      y_corr_s = {{(RW-WIDTH-3){1'b0}}, quo_q, 2'b01};
    end
    sum_s      = p_s + (sub_s ? ~y_s : y_s) + {{(RW-1){1'b0}}, adder_cin_s};
    digit_s    = ~sum_s[RW-1];
    rem_fix_s  = sum_s[RW-1] ? (sum_s + y_corr_s) : sum_s;
    quo_next_s = {quo_q[WIDTH-1:0], digit_s};
    last_s     = (cnt_q == (div_q ? LAST_DIV : LAST_SQRT));
  end

  // Next-state logic and register updates for the sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    res_d    = res_q;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (Start_SI) begin
          state_d = INIT;
          div_d   = Div_SI;
          opa_d   = Operand_a_DI;
          opb_d   = Operand_b_DI;
        end
      end
      INIT: begin
        if (kill_s) begin
          state_d = IDLE;
        end else begin
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (kill_s) begin
          state_d = IDLE;
        end else begin
          rem_d = sum_s;
          quo_d = quo_next_s;
          cnt_d = cnt_q + 1'b1;
          if (!div_q) begin
            opa_d = {opa_q[WIDTH-3:0], 2'b00};
          end
          if (last_s) begin
            state_d  = DONE;
            res_d    = quo_next_s;
            sticky_d = |rem_fix_s;
          end
        end
      end
      DONE: begin
        if (kill_s) begin
          state_d = IDLE;
        end else if (Start_SI) begin
          state_d = INIT;
          div_d   = Div_SI;
          opa_d   = Operand_a_DI;
          opb_d   = Operand_b_DI;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
    end
  end

  assign Ready_SO     = (state_q == IDLE) || (state_q == DONE);
  assign Busy_SO      = (state_q == INIT) || (state_q == ITER);
  assign Done_SO      = (state_q == DONE);
  assign Result_DO    = res_q;
  assign Sticky_SO    = sticky_q;
  assign Dbg_State_SO = state_q;

endmodule
